// File: rtl/iir_biquad_tdm.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_tdm
// Purpose  : Direct-form-I biquad for NCH channels sharing one multiplier.
//            Define IIR_SAT_EN for output clamping with ovf flag.
// Revision : 1.0
// ============================================================================
module iir_biquad_tdm #(
    parameter int W    = 11,
    parameter int CW   = 12,
    parameter int FRAC = 10,
    parameter int NCH  = 4,
    parameter logic signed [CW-1:0] B0 = CW'(256),
    parameter logic signed [CW-1:0] B1 = CW'(512),
    parameter logic signed [CW-1:0] B2 = CW'(256),
    parameter logic signed [CW-1:0] A1 = CW'(-512),
    parameter logic signed [CW-1:0] A2 = CW'(256),
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CHW-1:0]      in_ch,
    input  logic signed [W-1:0] x,
    output logic                out_valid,
    output logic [CHW-1:0]      out_ch,
    output logic signed [W-1:0] y,
    output logic                ovf
);

    localparam int PW  = W + CW;
    localparam int AW  = W + CW + 3;
    localparam int NSL = 2 ** CHW;
    // One bit per encodable channel index; set only for channels that exist.
    localparam logic [NSL-1:0]        c_ch_ok = {NSL{1'b1}} >> (NSL - NCH);
    localparam logic signed [AW-1:0]  c_half  = AW'(2 ** (FRAC - 1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC0 = 3'd1,
        S_MAC1 = 3'd2,
        S_MAC2 = 3'd3,
        S_MAC3 = 3'd4,
        S_MAC4 = 3'd5,
        S_DONE = 3'd6,
        S_SKIP = 3'd7
    } state_t;

    state_t                r_state;
    logic [CHW-1:0]        r_ch;
    logic signed [W-1:0]   r_x;
    logic signed [W-1:0]   r_x1 [NCH];
    logic signed [W-1:0]   r_x2 [NCH];
    logic signed [W-1:0]   r_y1 [NCH];
    logic signed [W-1:0]   r_y2 [NCH];
    logic signed [AW-1:0]  r_acc;
    logic                  r_out_valid;
    logic [CHW-1:0]        r_out_ch;
    logic signed [W-1:0]   r_y;

    logic signed [W-1:0]   w_smp;
    logic signed [CW-1:0]  w_coef;
    logic                  w_sub;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_prod_ext;
    logic signed [AW-1:0]  w_base;
    logic signed [AW-1:0]  w_acc;
    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_shr;
    logic signed [W-1:0]   w_y;

    // Feedback terms are subtracted rather than negating A1/A2, so a
    // coefficient of -2^(CW-1) cannot overflow.
    always_comb begin
        w_smp  = r_x;
        w_coef = B0;
        w_sub  = 1'b0;
        case (r_state)
            S_MAC1: begin w_smp = r_x1[r_ch]; w_coef = B1; end
            S_MAC2: begin w_smp = r_x2[r_ch]; w_coef = B2; end
            S_MAC3: begin w_smp = r_y1[r_ch]; w_coef = A1; w_sub = 1'b1; end
            S_MAC4: begin w_smp = r_y2[r_ch]; w_coef = A2; w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_prod     = w_smp * w_coef;
    assign w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    assign w_base     = (r_state == S_MAC0) ? '0 : r_acc;
    assign w_acc      = w_sub ? (w_base - w_prod_ext) : (w_base + w_prod_ext);
    assign w_sum      = r_acc + c_half;
    assign w_shr      = w_sum >>> FRAC;

`ifdef IIR_SAT_EN
    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_ovf = !((&w_shr[AW-1:W-1]) || !(|w_shr[AW-1:W-1]));
        if (w_ovf)
            w_y = w_shr[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            w_y = w_shr[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (r_state == S_DONE)
            r_ovf <= w_ovf;
    end

    assign ovf = r_ovf;
`else
    assign w_y = W'(w_shr);
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_x         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_y         <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_ch    <= in_ch;
                        r_state <= c_ch_ok[in_ch] ? S_MAC0 : S_SKIP;
                    end
                end
                S_MAC0: begin r_acc <= w_acc; r_state <= S_MAC1; end
                S_MAC1: begin r_acc <= w_acc; r_state <= S_MAC2; end
                S_MAC2: begin r_acc <= w_acc; r_state <= S_MAC3; end
                S_MAC3: begin r_acc <= w_acc; r_state <= S_MAC4; end
                S_MAC4: begin r_acc <= w_acc; r_state <= S_DONE; end
                S_DONE: begin
                    r_y           <= w_y;
                    r_out_ch      <= r_ch;
                    r_out_valid   <= 1'b1;
                    r_x2[r_ch]    <= r_x1[r_ch];
                    r_x1[r_ch]    <= r_x;
                    r_y2[r_ch]    <= r_y1[r_ch];
                    r_y1[r_ch]    <= w_y;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign y         = r_y;

endmodule
`default_nettype wire
